// File: rtl/servo_motion_sequencer_if.sv
// Command channel for the servo motion sequencer: target offset plus dwell,
// carried on a valid/ready handshake.
interface servo_motion_sequencer_if #(
  parameter int POS_W   = 17,
  parameter int DWELL_W = 8
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [POS_W-1:0]   cmd_pos;
  logic [DWELL_W-1:0] cmd_dwell;

  modport master (
    output cmd_valid,
    output cmd_pos,
    output cmd_dwell,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pos,
    input  cmd_dwell,
    output cmd_ready
  );
endinterface

// File: rtl/servo_motion_sequencer.sv
// Single-servo motion sequencer: owns the frame counter and PWM output, ramps
// the pulse offset toward commanded targets one bounded step per frame.
module servo_motion_sequencer #(
  parameter int FRAME_CLKS = 1000000,
  parameter int MIN_PULSE  = 20000,
  parameter int MAX_OFFSET = 110000,
  parameter int STEP       = 500,
  parameter int POS_W      = 17,
  parameter int DWELL_W    = 8
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  servo_motion_sequencer_if.slave cmd,
  input  logic                   abort,
  output logic                   servo,
  output logic [POS_W-1:0]       pos,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_tick
);

  localparam int CNT_W   = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int SH_BASE = ((CNT_W > POS_W) ? CNT_W : POS_W) + 1;
  localparam int SH_W    = (SH_BASE > 20) ? SH_BASE : 20;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_CLKS - 1);
  localparam logic [POS_W-1:0]   MAX_POS  = POS_W'(MAX_OFFSET);
  localparam logic [POS_W-1:0]   STEP_POS = POS_W'(STEP);
  localparam logic [SH_W-1:0]    MIN_SH   = SH_W'(MIN_PULSE);
  localparam logic [DWELL_W-1:0] DWELL_1  = DWELL_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_p0;
  logic [SH_W-1:0]    shadow_p0;
  logic               servo_p1;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_q, done_d;
  logic               accept;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p);
    return (p > MAX_POS) ? MAX_POS : p;
  endfunction

  // Compare before subtracting so the distance never wraps.
  function automatic logic [POS_W-1:0] pos_dist(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [POS_W-1:0] step_toward(input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] tgt);
    if (pos_dist(cur, tgt) <= STEP_POS)
      return tgt;
    else if (tgt > cur)
      return cur + STEP_POS;
    else
      return cur - STEP_POS;
  endfunction

  assign frame_tick    = (cnt_p0 == CNT_LAST);
  assign cmd.cmd_ready = rst_n && (state_q == IDLE) && !abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign servo = servo_p1;
  assign pos   = pos_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // Stage 0: frame counter and per-frame pulse-width shadow.
  // Stage 1: registered PWM compare, one clock behind the counter.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0    <= '0;
      shadow_p0 <= MIN_SH;
      servo_p1  <= 1'b0;
    end else begin
      cnt_p0   <= frame_tick ? '0 : cnt_p0 + CNT_W'(1);
      servo_p1 <= (SH_W'(cnt_p0) < shadow_p0);
      if (frame_tick)
        shadow_p0 <= MIN_SH + SH_W'(pos_d);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      target_q <= '0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      done_q   <= done_d;
    end
  end

  // Abort wins over any frame-edge update; position simply stays put.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            target_d = clamp_pos(cmd.cmd_pos);
            dwell_d  = cmd.cmd_dwell;
            state_d  = RAMP;
          end
        end
        RAMP: begin
          if (frame_tick) begin
            pos_d = step_toward(pos_q, target_q);
            if (pos_dist(pos_q, target_q) <= STEP_POS) begin
              if (dwell_q != '0) begin
                state_d = DWELL;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        DWELL: begin
          if (frame_tick) begin
            dwell_d = dwell_q - DWELL_1;
            if (dwell_q == DWELL_1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Scoreboard bench for servo_motion_sequencer: stimulus queues per-frame
// expectations, a monitor checks them at every frame edge.
module tb_servo_motion_sequencer;
  localparam int FRAME_CLKS = 100;
  localparam int MIN_PULSE  = 20;
  localparam int MAX_OFFSET = 60;
  localparam int STEP       = 10;
  localparam int POS_W      = 17;
  localparam int DWELL_W    = 4;

  logic             mclk  = 1'b0;
  logic             rst_n = 1'b0;
  logic             abort = 1'b0;
  logic             servo, busy, done, frame_tick;
  logic [POS_W-1:0] pos;

  servo_motion_sequencer_if #(.POS_W(POS_W), .DWELL_W(DWELL_W)) cmd_if ();

  servo_motion_sequencer #(
    .FRAME_CLKS(FRAME_CLKS), .MIN_PULSE(MIN_PULSE), .MAX_OFFSET(MAX_OFFSET),
    .STEP(STEP), .POS_W(POS_W), .DWELL_W(DWELL_W)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .cmd(cmd_if.slave), .abort(abort),
    .servo(servo), .pos(pos), .busy(busy), .done(done), .frame_tick(frame_tick)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int pos;
    int busy;
    int done;
    int width;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stray_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input int b, input int d, input int w);
    rec_t r;
    r.pos = p; r.busy = b; r.done = d; r.width = w;
    exp_q.push_back(r);
  endtask

  task automatic wait_edges(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      do begin
        @(negedge mclk);
        guard++;
      end while (!frame_tick && guard < 300);
      if (!frame_tick) begin
        checks++;
        failures++;
        $display("FAIL frame_wait: got no frame_tick expected one within 300 clks");
      end
      @(posedge mclk);
      #2;
    end
  endtask

  task automatic send(input int p, input int d);
    int guard = 0;
    @(negedge mclk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pos   = POS_W'(p);
    cmd_if.cmd_dwell = DWELL_W'(d);
    while (!cmd_if.cmd_ready && guard < 2000) begin
      @(negedge mclk);
      guard++;
    end
    if (!cmd_if.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_wait: got cmd_ready=0 expected 1 within 2000 clks");
    end
    @(posedge mclk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: frame_tick sampled before the edge marks a frame edge; outputs
  // are read just after it and servo-high clocks are accumulated per frame.
  int   mon_cyc = 0;
  int   mon_width = 0;
  logic mon_ft;
  rec_t mon_r;

  initial begin
    forever begin
      @(negedge mclk);
      mon_ft = frame_tick;
      @(posedge mclk);
      #1;
      if (!rst_n) begin
        mon_cyc   = 0;
        mon_width = 0;
      end else begin
        mon_cyc++;
        if (servo) mon_width++;
        if (mon_ft) begin
          check("frame_period", 32'(mon_cyc), 32'(FRAME_CLKS));
          mon_cyc = 0;
          if (exp_q.size() > 0) begin
            mon_r = exp_q.pop_front();
            check("pos", 32'(pos), 32'(mon_r.pos));
            check("busy", 32'(busy), 32'(mon_r.busy));
            check("done", 32'(done), 32'(mon_r.done));
            check("servo_width", 32'(mon_width), 32'(mon_r.width));
          end
          mon_width = 0;
        end else if (done) begin
          stray_done++;
        end
      end
    end
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pos   = '0;
    cmd_if.cmd_dwell = '0;

    // Reset state
    repeat (3) @(negedge mclk);
    check("rst_servo", 32'(servo), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 1: idle frames at minimum pulse
    push(0, 0, 0, 20); push(0, 0, 0, 20);
    wait_edges(2);

    // 2: ramp up to 35, then back down to 0
    push(10, 1, 0, 20); push(20, 1, 0, 30); push(30, 1, 0, 40);
    push(35, 0, 1, 50); push(35, 0, 0, 55);
    repeat (50) @(negedge mclk);
    send(35, 0);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_edges(5);

    push(25, 1, 0, 55); push(15, 1, 0, 45); push(5, 1, 0, 35);
    push(0, 0, 1, 25); push(0, 0, 0, 20);
    repeat (40) @(negedge mclk);
    send(0, 0);
    wait_edges(5);

    // 3: command above MAX_OFFSET is clamped
    push(10, 1, 0, 20); push(20, 1, 0, 30); push(30, 1, 0, 40);
    push(40, 1, 0, 50); push(50, 1, 0, 60); push(60, 0, 1, 70);
    push(60, 0, 0, 80);
    repeat (20) @(negedge mclk);
    send(100, 0);
    wait_edges(7);

    // 4: ramp down with dwell; a second command waits on valid until idle
    push(50, 1, 0, 80); push(40, 1, 0, 70); push(30, 1, 0, 60);
    push(20, 1, 0, 50); push(10, 1, 0, 40); push(0, 1, 0, 30);
    push(0, 1, 0, 20); push(0, 0, 1, 20);
    push(10, 1, 0, 20); push(20, 0, 1, 30); push(20, 0, 0, 40);
    repeat (10) @(negedge mclk);
    send(0, 2);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pos   = POS_W'(20);
    cmd_if.cmd_dwell = DWELL_W'(0);
    @(negedge mclk);
    check("ready_low_busy", 32'(cmd_if.cmd_ready), 32'd0);
    wait_edges(7);
    @(negedge mclk);
    check("ready_low_dwell", 32'(cmd_if.cmd_ready), 32'd0);
    wait_edges(1);
    send(20, 0);
    wait_edges(3);

    // 5: abort on a frame edge during a ramp, with a command pending
    push(30, 1, 0, 40);
    repeat (30) @(negedge mclk);
    send(60, 0);
    wait_edges(1);
    push(30, 0, 0, 50); push(20, 1, 0, 50); push(10, 1, 0, 40);
    push(0, 0, 1, 30); push(0, 0, 0, 20);
    begin
      int guard = 0;
      do begin
        @(negedge mclk);
        guard++;
      end while (!frame_tick && guard < 300);
    end
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pos   = POS_W'(0);
    cmd_if.cmd_dwell = DWELL_W'(0);
    #1;
    check("ready_low_abort", 32'(cmd_if.cmd_ready), 32'd0);
    @(posedge mclk);
    #1;
    abort = 1'b0;
    check("busy_after_abort", 32'(busy), 32'd0);
    @(posedge mclk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check("accept_after_abort", 32'(busy), 32'd1);
    wait_edges(4);

    // 6: asynchronous reset mid-ramp
    push(10, 1, 0, 20); push(20, 1, 0, 30);
    repeat (15) @(negedge mclk);
    send(40, 0);
    wait_edges(2);
    repeat (30) @(negedge mclk);
    check("servo_before_reset", 32'(servo), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_servo", 32'(servo), 32'd0);
    check("areset_pos", 32'(pos), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_ready", 32'(cmd_if.cmd_ready), 32'd0);
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    push(0, 0, 0, 20); push(0, 0, 0, 20);
    wait_edges(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("stray_done", 32'(stray_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_motion_sequencer.md
Name: servo_motion_sequencer

Overview:
Motion controller for one hobby servo on the 50 MHz board clock. It owns the 20 ms frame counter and the PWM pulse output. It accepts target-position commands over a valid/ready handshake and ramps the pulse-width offset toward each target by a fixed step per frame. After arrival it optionally dwells for a set number of frames, then reports completion. It replaces the free-running toggle-driven control loop as the block that sequences the servo PWM datapath.

Parameters:
FRAME_CLKS, 1000000, clocks per servo frame (20 ms at 50 MHz)
MIN_PULSE, 20000, pulse width in clocks at offset 0
MAX_OFFSET, 110000, largest allowed offset; commands above this are clamped
STEP, 500, maximum offset change per frame
POS_W, 17, width of position/offset values
DWELL_W, 8, width of the dwell frame count

Ports:
mclk  in  1  board clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_pos  in  POS_W  target offset in clocks above MIN_PULSE
cmd_dwell  in  DWELL_W  frames to hold at target before done
abort  in  1  stop motion immediately, hold current position
servo  out  1  PWM pulse to servo
pos  out  POS_W  current commanded offset
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
frame_tick  out  1  high during the last cycle of each frame

Behaviour:
- Reset (async, rst_n=0): counter=0, pos=0, target=0, dwell count=0, pulse shadow=MIN_PULSE, state=IDLE, servo=0, done=0, busy=0. cmd_ready is 0 while rst_n=0.
- Frame counter: counts 0..FRAME_CLKS-1, then wraps to 0. frame_tick = (counter == FRAME_CLKS-1).
- "Frame edge" means the clock edge where frame_tick=1. All position, dwell and shadow updates happen only on frame edges, except for accept and abort.
- Pulse shadow: loaded with MIN_PULSE + (pos value after this edge) on every frame edge. The width never changes mid-frame.
- servo is registered: servo <= (counter < shadow). It is high for exactly shadow clocks per frame, lagging counter by 1 clk.
- Handshake: cmd_ready = (state==IDLE) && !abort. A command is accepted when cmd_valid && cmd_ready.
  - On accept: target <= min(cmd_pos, MAX_OFFSET), dwell count <= cmd_dwell, state <= RAMP.
  - An accept on a frame edge does not move pos on that edge. The first step happens on the next frame edge.
- States:
  - IDLE: pos holds.
  - RAMP, on frame edge, with d = |target - pos|:
    - d > STEP: pos <= pos +/- STEP toward target.
    - d <= STEP: pos <= target. Then go to DWELL if dwell count > 0; otherwise go to IDLE and pulse done.
    - If pos == target at accept, arrival occurs on the first frame edge.
  - DWELL, on frame edge: dwell count <= dwell count - 1. When it reaches 0, go to IDLE and pulse done on that edge.
- done: one-cycle pulse, registered, asserted the cycle after the transition edge.
- abort:
  - In any state, abort=1 at a clock edge forces state to IDLE.
  - pos and shadow hold; no done pulse.
  - abort has priority over a frame-edge update in the same cycle.
  - Frame counter and servo continue unaffected.
- Arithmetic: pos and target are unsigned POS_W bits. Step math is done without underflow (compare before subtract). pos never exceeds MAX_OFFSET. MIN_PULSE+pos is computed at 20+ bits.
- Reset mid-operation: all state is lost immediately. The first frame after release starts at counter 0.

Test Plan:
Bench parameters: FRAME_CLKS=100, MIN_PULSE=20, MAX_OFFSET=60, STEP=10, DWELL_W=4.
1. Reset, release, no commands -> cmd_ready=1, pos=0, frame_tick every 100 clks, servo high 20 clks per frame.
2. cmd_pos=35, dwell=0 accepted mid-frame -> pos 10,20,30,35 on the next four frame edges. done pulses once after the 4th edge. Following frame's servo width=55. busy low after done.
3. cmd_pos=100 (clamp) from pos 0 -> pos reaches 60 after 6 frame edges, never exceeds 60. Servo width 80.
4. From pos 60, cmd_pos=0, dwell=2 -> 6 ramp-down frames to 0, then 2 dwell frames, then done. cmd_ready=0 and cmd_valid held high is not accepted until IDLE.
5. During ramp at pos=30, assert abort for 1 cycle with cmd_valid=1, coincident with frame_tick -> state IDLE, pos stays 30, no done, command not accepted that cycle. Next cycle (abort=0) the command is accepted.
6. Drop rst_n asynchronously mid-ramp between clock edges -> servo, pos, busy, cmd_ready go to 0 immediately. After release, servo width is 20 and counter restarts at 0.
